// File: rtl/vga_pixel_fetch.sv
// Pixel fetch stage behind the VGA timing generator: frame-buffer reads with
// integer upscaling, sync alignment to read latency, bank select, frame count.
module vga_pixel_fetch #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SCALE_SHIFT = 1,
    parameter int FB_AW       = 17,
    parameter int RD_LAT      = 2
) (
    input  logic             vga_pclk,
    input  logic             sys_rst,
    input  logic [9:0]       vga_paddr_h,
    input  logic [9:0]       vga_paddr_v,
    input  logic             vga_hsync_i,
    input  logic             vga_vsync_i,
    input  logic             fb_bank_req,
    output logic             fb_rd_en,
    output logic [FB_AW-1:0] fb_rd_addr,
    output logic             fb_rd_bank,
    input  logic [15:0]      fb_rd_data,
    output logic [3:0]       vga_r,
    output logic [3:0]       vga_g,
    output logic [3:0]       vga_b,
    output logic             vga_hsync,
    output logic             vga_vsync,
    output logic             frame_start,
    output logic [7:0]       frame_cnt
);

    localparam int PIPE = RD_LAT + 2;
    localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
    localparam logic [9:0] V_LIM = 10'(V_ACTIVE);
    localparam logic [FB_AW-1:0] H_SRC = FB_AW'(H_ACTIVE >> SCALE_SHIFT);

    logic             w_active;
    logic             w_origin;
    logic [9:0]       w_h_src;
    logic [9:0]       w_v_src;
    logic [FB_AW-1:0] w_addr;

    logic [PIPE-1:0]  r_hs_sr;
    logic [PIPE-1:0]  r_vs_sr;
    logic [PIPE-2:0]  r_act_sr;
    logic [PIPE-2:0]  r_org_sr;

    assign w_active = (vga_paddr_h < H_LIM) && (vga_paddr_v < V_LIM);
    assign w_origin = (vga_paddr_h == 10'd0) && (vga_paddr_v == 10'd0);
    assign w_h_src  = vga_paddr_h >> SCALE_SHIFT;
    assign w_v_src  = vga_paddr_v >> SCALE_SHIFT;
    assign w_addr   = FB_AW'(w_v_src) * H_SRC + FB_AW'(w_h_src);

    assign vga_hsync = r_hs_sr[PIPE-1];
    assign vga_vsync = r_vs_sr[PIPE-1];

    always_ff @(posedge vga_pclk or posedge sys_rst) begin
        if (sys_rst) begin
            fb_rd_en   <= 1'b0;
            fb_rd_addr <= '0;
            fb_rd_bank <= 1'b0;
        end else begin
            fb_rd_en <= w_active;
            if (w_active)
                fb_rd_addr <= w_addr;
            // Bank only swaps at the frame origin so a frame never tears.
            if (w_origin)
                fb_rd_bank <= fb_bank_req;
        end
    end

    always_ff @(posedge vga_pclk or posedge sys_rst) begin
        if (sys_rst) begin
            r_hs_sr  <= '1;
            r_vs_sr  <= '1;
            r_act_sr <= '0;
            r_org_sr <= '0;
        end else begin
            r_hs_sr  <= {r_hs_sr[PIPE-2:0], vga_hsync_i};
            r_vs_sr  <= {r_vs_sr[PIPE-2:0], vga_vsync_i};
            r_act_sr <= {r_act_sr[PIPE-3:0], w_active};
            r_org_sr <= {r_org_sr[PIPE-3:0], w_origin};
        end
    end

    // Last stage lines up with read data arriving RD_LAT after the strobe.
    always_ff @(posedge vga_pclk or posedge sys_rst) begin
        if (sys_rst) begin
            vga_r       <= 4'd0;
            vga_g       <= 4'd0;
            vga_b       <= 4'd0;
            frame_start <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            if (r_act_sr[PIPE-2]) begin
                vga_r <= fb_rd_data[15:12];
                vga_g <= fb_rd_data[10:7];
                vga_b <= fb_rd_data[4:1];
            end else begin
                vga_r <= 4'd0;
                vga_g <= 4'd0;
                vga_b <= 4'd0;
            end
            frame_start <= r_org_sr[PIPE-2];
            if (r_org_sr[PIPE-2])
                frame_cnt <= frame_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: reset, colour path, addressing,
// blanking, sync delay, bank switching and frame counter wrap.
module tb_vga_pixel_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        hs_i;
    logic        vs_i;
    logic        bank_req;
    logic        rd_en;
    logic [16:0] rd_addr;
    logic        rd_bank;
    logic [15:0] rd_data;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        hs_o;
    logic        vs_o;
    logic        fstart;
    logic [7:0]  fcnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int first;
    int width;

    always #5 clk = ~clk;

    vga_pixel_fetch dut (
        .vga_pclk    (clk),
        .sys_rst     (rst),
        .vga_paddr_h (h),
        .vga_paddr_v (v),
        .vga_hsync_i (hs_i),
        .vga_vsync_i (vs_i),
        .fb_bank_req (bank_req),
        .fb_rd_en    (rd_en),
        .fb_rd_addr  (rd_addr),
        .fb_rd_bank  (rd_bank),
        .fb_rd_data  (rd_data),
        .vga_r       (r),
        .vga_g       (g),
        .vga_b       (b),
        .vga_hsync   (hs_o),
        .vga_vsync   (vs_o),
        .frame_start (fstart),
        .frame_cnt   (fcnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int hh, input int vv);
        h = 10'(hh);
        v = 10'(vv);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        h        = 10'd700;
        v        = 10'd490;
        hs_i     = 1'b1;
        vs_i     = 1'b1;
        bank_req = 1'b0;
        rd_data  = 16'hFFFF;
        #23;
        chk("rst_rgb", {20'd0, r, g, b}, 32'h0);
        chk("rst_hs", {31'd0, hs_o}, 32'd1);
        chk("rst_vs", {31'd0, vs_o}, 32'd1);
        chk("rst_en", {31'd0, rd_en}, 32'd0);
        chk("rst_bank", {31'd0, rd_bank}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // fill pipeline with visible pixels, then reset mid-line
        hs_i = 1'b0;
        for (int i = 0; i < 5; i++) tick(10 + i, 20);
        chk("pre_rgb", {20'd0, r, g, b}, 32'hFFF);
        chk("pre_hs", {31'd0, hs_o}, 32'd0);
        chk("pre_en", {31'd0, rd_en}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rgb", {20'd0, r, g, b}, 32'h0);
        chk("arst_hs", {31'd0, hs_o}, 32'd1);
        chk("arst_vs", {31'd0, vs_o}, 32'd1);
        chk("arst_en", {31'd0, rd_en}, 32'd0);
        chk("arst_fcnt", {24'd0, fcnt}, 32'd0);
        hs_i = 1'b1;
        h    = 10'd700;
        v    = 10'd490;
        #13;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // first pixel of a frame, colour path and addressing
        rd_data  = 16'hF81F;
        bank_req = 1'b1;
        chk("bank0", {31'd0, rd_bank}, 32'd0);
        tick(0, 0);
        chk("en_00", {31'd0, rd_en}, 32'd1);
        chk("addr_00", {15'd0, rd_addr}, 32'd0);
        chk("bank1", {31'd0, rd_bank}, 32'd1);
        tick(1, 0);
        chk("addr_10", {15'd0, rd_addr}, 32'd0);
        chk("fs_early", {31'd0, fstart}, 32'd0);
        tick(2, 0);
        chk("addr_20", {15'd0, rd_addr}, 32'd1);
        tick(3, 0);
        chk("rgb_00", {20'd0, r, g, b}, 32'hF0F);
        chk("fs_00", {31'd0, fstart}, 32'd1);
        chk("fcnt_1", {24'd0, fcnt}, 32'd1);
        tick(0, 1);
        chk("addr_01", {15'd0, rd_addr}, 32'd0);
        chk("fs_pulse", {31'd0, fstart}, 32'd0);
        tick(0, 2);
        chk("addr_02", {15'd0, rd_addr}, 32'd320);
        tick(5, 3);
        chk("addr_53", {15'd0, rd_addr}, 32'd322);
        tick(639, 479);
        chk("addr_last", {15'd0, rd_addr}, 32'd76799);

        // horizontal blanking with all-ones read data
        rd_data = 16'hFFFF;
        for (int hh = 640; hh < 800; hh++) begin
            tick(hh, 479);
            chk("blank_en", {31'd0, rd_en}, 32'd0);
            chk("blank_addr", {15'd0, rd_addr}, 32'd76799);
            if (hh == 642)
                chk("last_rgb", {20'd0, r, g, b}, 32'hFFF);
            if (hh >= 643)
                chk("blank_rgb", {20'd0, r, g, b}, 32'h0);
        end

        // hsync delay and width
        first = -1;
        width = 0;
        for (int i = 0; i < 200; i++) begin
            hs_i = !(i >= 10 && i < 106);
            tick(700, 490);
            if (hs_o === 1'b0) begin
                if (first < 0) first = i;
                width++;
            end
        end
        chk("hs_fall", 32'(first), 32'd13);
        chk("hs_width", 32'(width), 32'd96);

        // vsync delay and width (two lines)
        first = -1;
        width = 0;
        for (int i = 0; i < 1700; i++) begin
            vs_i = !(i >= 10 && i < 1610);
            tick(700, 490);
            if (vs_o === 1'b0) begin
                if (first < 0) first = i;
                width++;
            end
        end
        chk("vs_fall", 32'(first), 32'd13);
        chk("vs_width", 32'(width), 32'd1600);

        // mid-frame bank request is ignored until the next origin
        bank_req = 1'b0;
        tick(0, 100);
        chk("bank_mid", {31'd0, rd_bank}, 32'd1);
        tick(5, 100);
        chk("bank_mid2", {31'd0, rd_bank}, 32'd1);
        tick(0, 0);
        chk("bank_swap", {31'd0, rd_bank}, 32'd0);
        tick(1, 0);
        tick(2, 0);
        tick(3, 0);
        chk("fcnt_2", {24'd0, fcnt}, 32'd2);

        // frame counter wrap
        for (int i = 0; i < 253; i++) tick(0, 0);
        tick(1, 0);
        tick(2, 0);
        tick(3, 0);
        chk("fcnt_255", {24'd0, fcnt}, 32'd255);
        tick(0, 0);
        tick(1, 0);
        tick(2, 0);
        tick(3, 0);
        chk("fcnt_wrap", {24'd0, fcnt}, 32'd0);
        chk("fs_wrap", {31'd0, fstart}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
